// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle for the timer/compare peripheral.
// Signal names follow the responder's point of view (_i into the timer, _o out of it).
interface wb_timer_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [1:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, input dat_o, ack_o);
  modport slave  (input cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/wb_timer.sv
// Wishbone classic timer/compare responder: prescaled up-counter, compare match
// flag (W1C) and a registered level interrupt gated by CTRL.IE.
module wb_timer #(
  parameter int CWIDTH  = 32,
  parameter int PSWIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_timer_if.slave   wb,
  output logic        irq_o
);
  localparam logic [1:0]  A_CTRL = 2'd0, A_COUNT = 2'd1, A_CMP = 2'd2, A_STAT = 2'd3;
  localparam logic [31:0] CTRL_MASK = 32'h7 | (((32'd1 << PSWIDTH) - 32'd1) << 8);

  logic [31:0]         ctrl;
  logic [CWIDTH-1:0]   count, compare;
  logic [PSWIDTH-1:0]  ps_cnt, presc;
  logic                match, en, auto_rl, ie;
  logic                access, wr, rd, tick, hit, ps_wr;
  logic                wr_ctrl, wr_count, wr_cmp, wr_stat;
  logic [31:0]         wmask, count_ext, cmp_ext, ctrl_mrg, count_mrg, cmp_mrg, rdata;

  assign access = wb.cyc_i & wb.stb_i & ~wb.ack_o;
  assign wr     = access & wb.we_i;
  assign rd     = access & ~wb.we_i;

  assign wr_ctrl  = wr && (wb.adr_i == A_CTRL);
  assign wr_count = wr && (wb.adr_i == A_COUNT);
  assign wr_cmp   = wr && (wb.adr_i == A_CMP);
  assign wr_stat  = wr && (wb.adr_i == A_STAT);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign wmask[8*b +: 8] = {8{wb.sel_i[b]}};
  end

  assign count_ext = 32'(count);
  assign cmp_ext   = 32'(compare);
  assign ctrl_mrg  = (ctrl      & ~wmask) | (wb.dat_i & wmask);
  assign count_mrg = (count_ext & ~wmask) | (wb.dat_i & wmask);
  assign cmp_mrg   = (cmp_ext   & ~wmask) | (wb.dat_i & wmask);

  assign en      = ctrl[0];
  assign auto_rl = ctrl[1];
  assign ie      = ctrl[2];
  assign presc   = ctrl[8 +: PSWIDTH];

  // Tick decisions use the CTRL value already registered, so a CTRL write lands next cycle.
  assign tick  = en && (ps_cnt == presc);
  assign hit   = (count == compare);
  assign ps_wr = wr_ctrl && (|wmask[8 +: PSWIDTH]);

  always_comb begin
    rdata = '0;
    case (wb.adr_i)
      A_CTRL:  rdata = ctrl;
      A_COUNT: rdata = count_ext;
      A_CMP:   rdata = cmp_ext;
      A_STAT:  rdata = {31'b0, match};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb.ack_o <= 1'b0;
      wb.dat_o <= '0;
    end else begin
      wb.ack_o <= access;
      if (rd) wb.dat_o <= rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl   <= '0;
      ps_cnt <= '0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_mrg & CTRL_MASK;
      if (ps_wr || !en || tick) ps_cnt <= '0;
      else                      ps_cnt <= ps_cnt + PSWIDTH'(1);
    end
  end

  // A bus write to COUNT overrides the tick update in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count   <= '0;
      compare <= '1;
    end else begin
      if (wr_count)  count <= count_mrg[CWIDTH-1:0];
      else if (tick) count <= (hit && auto_rl) ? '0 : count + CWIDTH'(1);
      if (wr_cmp) compare <= cmp_mrg[CWIDTH-1:0];
    end
  end

  // Match-set has priority over a coincident W1C.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      match <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (tick && hit)                              match <= 1'b1;
      else if (wr_stat && wb.sel_i[0] && wb.dat_i[0]) match <= 1'b0;
      irq_o <= match & ie;
    end
  end
endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: register vector table, read scoreboard,
// and hand-timed sequences for prescale, auto-reload, collisions, reset and wrap.
module tb_wb_timer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic irq_o;

  wb_timer_if bif();

  wb_timer #(.CWIDTH(32), .PSWIDTH(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wb    (bif),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sbq[$];
  sb_t mon_e;

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read data is compared against the scoreboard in the middle of the ack cycle.
  always @(negedge clk_i) begin
    if (rst_i && bif.ack_o === 1'b1 && bif.we_i === 1'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got read ack data %h expected no read", bif.dat_o);
      end else begin
        mon_e = sbq.pop_front();
        check(mon_e.name, bif.dat_o, mon_e.exp);
      end
    end
  end

  task automatic bus(input logic w, input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    @(posedge clk_i); #1;
    bif.cyc_i = 1'b1; bif.stb_i = 1'b1; bif.we_i = w;
    bif.sel_i = s;    bif.adr_i = a;    bif.dat_i = d;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (bif.ack_o !== 1'b1 && n < 8);
    if (bif.ack_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: no ack after %0d cycles, expected ack after 1", n);
    end
    bif.cyc_i = 1'b0; bif.stb_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    e.exp = exp; e.name = name;
    sbq.push_back(e);
    bus(1'b0, a, 4'hF, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    bus(1'b1, a, s, d);
  endtask

  // Counts cycles until irq_o is seen high, bounded at 40.
  task automatic wait_irq(input string name, input int exp_n);
    int n;
    n = 0;
    while (irq_o !== 1'b1 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    check(name, n, exp_n);
  endtask

  initial begin
    bif.cyc_i = 1'b0; bif.stb_i = 1'b0; bif.we_i = 1'b0;
    bif.sel_i = 4'h0; bif.adr_i = 2'd0; bif.dat_i = 32'h0;

    vt[0]  = '{1'b0, 2'd0, 4'hF, 32'h0,         32'h0,         "rst_ctrl"};
    vt[1]  = '{1'b0, 2'd1, 4'hF, 32'h0,         32'h0,         "rst_count"};
    vt[2]  = '{1'b0, 2'd2, 4'hF, 32'h0,         32'hFFFF_FFFF, "rst_compare"};
    vt[3]  = '{1'b0, 2'd3, 4'hF, 32'h0,         32'h0,         "rst_status"};
    vt[4]  = '{1'b1, 2'd1, 4'h3, 32'h1234_5678, 32'h0,         "wr_count_lo"};
    vt[5]  = '{1'b0, 2'd1, 4'hF, 32'h0,         32'h0000_5678, "count_sel_lo"};
    vt[6]  = '{1'b1, 2'd2, 4'hC, 32'hAABB_CCDD, 32'h0,         "wr_cmp_hi"};
    vt[7]  = '{1'b0, 2'd2, 4'hF, 32'h0,         32'hAABB_FFFF, "compare_sel_hi"};
    vt[8]  = '{1'b1, 2'd0, 4'hF, 32'hFFFF_FFFE, 32'h0,         "wr_ctrl_all"};
    vt[9]  = '{1'b0, 2'd0, 4'hF, 32'h0,         32'h0000_FF06, "ctrl_mask"};
    vt[10] = '{1'b1, 2'd0, 4'hF, 32'h0,         32'h0,         "wr_ctrl_zero"};
    vt[11] = '{1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 32'h0,         "wr_status_idle"};
    vt[12] = '{1'b0, 2'd3, 4'hF, 32'h0,         32'h0,         "status_w1c_idle"};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", {31'b0, bif.ack_o}, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    check("rst_dat_o", bif.dat_o, 32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vt[i].we) wr(vt[i].adr, vt[i].sel, vt[i].dat);
      else          rd(vt[i].adr, vt[i].exp, vt[i].name);
    end

    // Held strobe: ack alternates 1,0,1,0... (no-lane write has no side effect)
    @(posedge clk_i); #1;
    bif.cyc_i = 1'b1; bif.stb_i = 1'b1; bif.we_i = 1'b1; bif.sel_i = 4'h0; bif.adr_i = 2'd3;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      check($sformatf("ack_hold%0d", k), {31'b0, bif.ack_o}, {31'b0, (k % 2 == 0)});
    end
    bif.cyc_i = 1'b0; bif.stb_i = 1'b0;

    // Prescale 4: ticks every 5 cycles, match on the 4th tick (COUNT 3->4)
    wr(2'd2, 4'hF, 32'd3);
    wr(2'd1, 4'hF, 32'd0);
    wr(2'd0, 4'hF, 32'h0000_0405);
    wait_irq("ps_irq_cycles", 21);
    rd(2'd1, 32'd4, "ps_count_at_match");
    rd(2'd3, 32'd1, "ps_match");
    rd(2'd1, 32'd5, "ps_count_next");

    // Auto-reload, PRESCALE=0, COMPARE=2
    wr(2'd0, 4'hF, 32'h0);
    wr(2'd1, 4'hF, 32'h0);
    wr(2'd3, 4'h1, 32'h1);
    wr(2'd2, 4'hF, 32'd2);
    check("ar_irq_cleared", {31'b0, irq_o}, 32'h0);
    wr(2'd0, 4'hF, 32'h0000_0007);
    wait_irq("ar_first_match", 4);
    @(posedge clk_i);
    wr(2'd3, 4'h1, 32'h1);
    @(posedge clk_i); #1;
    check("ar_w1c_irq_low", {31'b0, irq_o}, 32'h0);
    wait_irq("ar_rematch", 2);

    // W1C lands on a match edge: match must survive
    wr(2'd3, 4'h1, 32'h1);
    rd(2'd3, 32'd1, "w1c_vs_match");
    rd(2'd1, 32'd0, "ar_count_0");
    rd(2'd1, 32'd2, "ar_count_2");
    rd(2'd1, 32'd1, "ar_count_1");

    // COUNT write coincides with a tick: written value wins, then counts on
    wr(2'd1, 4'hF, 32'd100);
    rd(2'd1, 32'd101, "count_wr_vs_tick");

    // Reset in the middle of an acked read
    check("pre_reset_irq", {31'b0, irq_o}, 32'h1);
    @(posedge clk_i); #1;
    bif.cyc_i = 1'b1; bif.stb_i = 1'b1; bif.we_i = 1'b0; bif.adr_i = 2'd0; bif.sel_i = 4'hF;
    @(posedge clk_i); #1;
    check("mid_ack_before_rst", {31'b0, bif.ack_o}, 32'h1);
    #1 rst_i = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, bif.ack_o}, 32'h0);
    check("mid_rst_irq", {31'b0, irq_o}, 32'h0);
    bif.cyc_i = 1'b0; bif.stb_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    rd(2'd0, 32'h0, "post_rst_ctrl");
    rd(2'd2, 32'hFFFF_FFFF, "post_rst_compare");
    rd(2'd3, 32'h0, "post_rst_status");

    // Wrap: COUNT all ones -> 0 with no match, PRESCALE=3
    wr(2'd2, 4'hF, 32'd5);
    wr(2'd1, 4'hF, 32'hFFFF_FFFF);
    wr(2'd0, 4'hF, 32'h0000_0301);
    rd(2'd1, 32'hFFFF_FFFF, "wrap_before_a");
    rd(2'd1, 32'hFFFF_FFFF, "wrap_before_b");
    rd(2'd1, 32'h0, "wrap_zero");
    rd(2'd3, 32'h0, "wrap_no_match");
    check("wrap_irq", {31'b0, irq_o}, 32'h0);

    repeat (2) @(posedge clk_i);
    check("sb_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
